lif_spike_monitor: RTL and testbench

- Downstream consumer of the LIF neuron spike output inside the tt_um_lif top.
- Detects spike events, counts them over a programmable cycle window and measures the inter-spike interval (ISI).
- Pushes one {count, ISI} record per window into a small FIFO drained via valid/ready, for uo_out/uio_out readout.

---
 rtl/lif_spike_monitor_if.sv | 13 +
 rtl/lif_spike_monitor.sv | 133 +++++++++++++
 tb/tb_lif_spike_monitor.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/lif_spike_monitor_if.sv
// Record readout channel of the LIF spike monitor: head record plus valid/ready.
interface lif_spike_monitor_if #(
   parameter int CNT_W = 8,
   parameter int ISI_W = 16
) ();
   logic             out_valid;
   logic             out_ready;
   logic [CNT_W-1:0] out_count;
   logic [ISI_W-1:0] out_isi;

   modport master (output out_valid, output out_count, output out_isi, input out_ready);
   modport slave  (input out_valid, input out_count, input out_isi, output out_ready);
endinterface

// File: rtl/lif_spike_monitor.sv
// Counts LIF spike events per programmable window, tracks the last inter-spike
// interval and queues one {count, ISI} record per window in a FWFT FIFO.
module lif_spike_monitor #(
   parameter int CNT_W      = 8,
   parameter int WIN_W      = 16,
   parameter int ISI_W      = 16,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         ena,
   input  logic                         spike_in,
   input  logic [WIN_W-1:0]             win_len,
   lif_spike_monitor_if.master          rec,
   output logic                         overflow,
   output logic [$clog2(FIFO_DEPTH):0]  fifo_level
);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int LW = AW + 1;

   function automatic logic [CNT_W-1:0] sat_inc_cnt(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + 1'b1;
   endfunction

   function automatic logic [ISI_W-1:0] sat_inc_isi(input logic [ISI_W-1:0] v);
      return (&v) ? v : v + 1'b1;
   endfunction

   logic             spike_q, spike_d;
   logic [WIN_W-1:0] wcnt_q, wcnt_d;
   logic [CNT_W-1:0] scnt_q, scnt_d;
   logic [ISI_W-1:0] icnt_q, icnt_d;
   logic [ISI_W-1:0] last_isi_q, last_isi_d;
   logic             isi_armed_q, isi_armed_d;
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [LW-1:0]    level_q, level_d;
   logic             overflow_q, overflow_d;
   logic [CNT_W-1:0] cnt_mem_q [FIFO_DEPTH];
   logic [CNT_W-1:0] cnt_mem_d [FIFO_DEPTH];
   logic [ISI_W-1:0] isi_mem_q [FIFO_DEPTH];
   logic [ISI_W-1:0] isi_mem_d [FIFO_DEPTH];

   logic             spike_ev, eow, pop, push;
   logic [CNT_W-1:0] rec_cnt;
   logic [ISI_W-1:0] isi_next, rec_isi;

   always_comb begin
      spike_ev = spike_in & ~spike_q & ena;
      // A shrinking win_len can leave wcnt past the new end; close the window at once.
      eow      = ena && (win_len != '0) && (wcnt_q >= win_len - WIN_W'(1));
      rec_cnt  = spike_ev ? sat_inc_cnt(scnt_q) : scnt_q;
      isi_next = sat_inc_isi(icnt_q);
      rec_isi  = (spike_ev && isi_armed_q) ? isi_next : last_isi_q;
      pop      = (level_q != '0) && rec.out_ready;
      push     = eow && ((level_q != LW'(FIFO_DEPTH)) || pop);

      spike_d     = spike_in;
      wcnt_d      = wcnt_q;
      scnt_d      = scnt_q;
      icnt_d      = icnt_q;
      last_isi_d  = last_isi_q;
      isi_armed_d = isi_armed_q;
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      overflow_d  = overflow_q;
      cnt_mem_d   = cnt_mem_q;
      isi_mem_d   = isi_mem_q;

      if (ena) begin
         if (win_len == '0 || eow) wcnt_d = '0;
         else                      wcnt_d = wcnt_q + 1'b1;
         icnt_d = isi_next;
      end
      if (eow)           scnt_d = '0;
      else if (spike_ev) scnt_d = sat_inc_cnt(scnt_q);

      // ISI spans window boundaries, so icnt is only cleared by a spike.
      if (spike_ev) begin
         if (isi_armed_q) last_isi_d = isi_next;
         icnt_d      = '0;
         isi_armed_d = 1'b1;
      end

      if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
      if (push) begin
         cnt_mem_d[wr_ptr_q] = rec_cnt;
         isi_mem_d[wr_ptr_q] = rec_isi;
         wr_ptr_d            = wr_ptr_q + 1'b1;
      end
      if (eow && !push) overflow_d = 1'b1;
      level_d = level_q + LW'(push) - LW'(pop);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         spike_q     <= 1'b0;
         wcnt_q      <= '0;
         scnt_q      <= '0;
         icnt_q      <= '0;
         last_isi_q  <= '0;
         isi_armed_q <= 1'b0;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         level_q     <= '0;
         overflow_q  <= 1'b0;
      end else begin
         spike_q     <= spike_d;
         wcnt_q      <= wcnt_d;
         scnt_q      <= scnt_d;
         icnt_q      <= icnt_d;
         last_isi_q  <= last_isi_d;
         isi_armed_q <= isi_armed_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         level_q     <= level_d;
         overflow_q  <= overflow_d;
      end
   end

   // Record storage holds data only; occupancy gates what is visible.
   always_ff @(posedge clk) begin
      cnt_mem_q <= cnt_mem_d;
      isi_mem_q <= isi_mem_d;
   end

   always_comb begin
      rec.out_valid = (level_q != '0);
      rec.out_count = rec.out_valid ? cnt_mem_q[rd_ptr_q] : '0;
      rec.out_isi   = rec.out_valid ? isi_mem_q[rd_ptr_q] : '0;
      overflow      = overflow_q;
      fifo_level    = level_q;
   end
endmodule

// File: tb/tb_lif_spike_monitor.sv
// Randomized and directed bench for lif_spike_monitor against a queue-based model.
module tb_lif_spike_monitor;
   localparam int CNT_W = 8;
   localparam int WIN_W = 16;
   localparam int ISI_W = 16;
   localparam int DEPTH = 4;
   localparam int CMAX  = (1 << CNT_W) - 1;
   localparam int IMAX  = (1 << ISI_W) - 1;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             ena = 1'b0;
   logic             spike_in = 1'b0;
   logic [WIN_W-1:0] win_len = '0;
   logic             overflow;
   logic [2:0]       fifo_level;

   lif_spike_monitor_if #(.CNT_W(CNT_W), .ISI_W(ISI_W)) rec ();

   lif_spike_monitor #(.CNT_W(CNT_W), .WIN_W(WIN_W), .ISI_W(ISI_W), .FIFO_DEPTH(DEPTH)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .ena        (ena),
      .spike_in   (spike_in),
      .win_len    (win_len),
      .rec        (rec),
      .overflow   (overflow),
      .fifo_level (fifo_level)
   );

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_fail = 0;

   task automatic chk(input string tag, input int unsigned got, input int unsigned exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
      end
   endtask

   // Behavioural model: window position, spike count and ISI as plain integers.
   typedef struct { int c; int i; } rec_t;
   rec_t m_q[$];
   int   m_wcnt, m_scnt, m_icnt, m_last;
   bit   m_armed, m_spq, m_ovf;

   function automatic int min2(input int a, input int b);
      return (a < b) ? a : b;
   endfunction

   function automatic void m_reset();
      m_q.delete();
      m_wcnt = 0; m_scnt = 0; m_icnt = 0; m_last = 0;
      m_armed = 0; m_spq = 0; m_ovf = 0;
   endfunction

   function automatic void m_step(input bit e, input bit s, input int wl, input bit r);
      bit   ev, end_win, popped, full;
      rec_t nr;
      ev      = s && !m_spq && e;
      end_win = e && (wl != 0) && (m_wcnt + 1 >= wl);
      full    = (m_q.size() == DEPTH);
      popped  = (m_q.size() > 0) && r;
      nr.c    = min2(m_scnt + (ev ? 1 : 0), CMAX);
      nr.i    = (ev && m_armed) ? min2(m_icnt + 1, IMAX) : m_last;
      if (e) begin
         m_wcnt = (wl == 0 || end_win) ? 0 : m_wcnt + 1;
         m_icnt = min2(m_icnt + 1, IMAX);
      end
      if (ev) begin
         if (m_armed) m_last = nr.i;
         m_icnt  = 0;
         m_armed = 1;
      end
      if (end_win)  m_scnt = 0;
      else if (ev)  m_scnt = min2(m_scnt + 1, CMAX);
      if (popped) void'(m_q.pop_front());
      if (end_win) begin
         if (!full || popped) m_q.push_back(nr);
         else                 m_ovf = 1;
      end
      m_spq = s;
   endfunction

   task automatic compare();
      chk("valid", rec.out_valid, (m_q.size() > 0));
      chk("level", fifo_level, m_q.size());
      chk("overflow", overflow, m_ovf);
      chk("count", rec.out_count, (m_q.size() > 0) ? m_q[0].c : 0);
      chk("isi", rec.out_isi, (m_q.size() > 0) ? m_q[0].i : 0);
   endtask

   task automatic cyc(input bit e, input bit s, input int wl, input bit r);
      ena = e; spike_in = s; win_len = wl[WIN_W-1:0]; rec.out_ready = r;
      @(posedge clk);
      m_step(e, s, wl, r);
      #1;
      compare();
   endtask

   // Asynchronous reset asserted between clock edges; outputs must clear at once.
   task automatic do_reset();
      #2;
      ena = 0; spike_in = 0; rec.out_ready = 0;
      rst_n = 0;
      #1;
      chk("rst_valid", rec.out_valid, 0);
      chk("rst_level", fifo_level, 0);
      chk("rst_overflow", overflow, 0);
      m_reset();
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1;
   endtask

   initial begin
      rec.out_ready = 0;
      m_reset();
      #1;
      do_reset();

      // Spikes at cycles 2, 5, 9 of a 10-cycle window.
      for (int i = 0; i < 10; i++) cyc(1, (i == 2 || i == 5 || i == 9), 10, 0);
      chk("a_count", rec.out_count, 3);
      chk("a_isi", rec.out_isi, 4);
      chk("a_valid", rec.out_valid, 1);

      // Spike held high: a single event.
      do_reset();
      for (int i = 0; i < 20; i++) cyc(1, 1, 4, 1);

      // Overflow with consumer stalled, then in-order drain.
      do_reset();
      for (int i = 0; i < 18; i++) cyc(1, $urandom_range(0, 1), 3, 0);
      chk("c_level", fifo_level, 4);
      chk("c_overflow", overflow, 1);
      for (int i = 0; i < 4; i++) cyc(0, 0, 3, 1);
      chk("c_drained", fifo_level, 0);

      // Full FIFO with a pop exactly on the end-of-window cycle.
      do_reset();
      for (int i = 0; i < 15; i++) cyc(1, $urandom_range(0, 1), 3, (i == 14));
      chk("d_level", fifo_level, 4);
      chk("d_overflow", overflow, 0);

      // Saturating count, ISI of 2.
      do_reset();
      for (int i = 0; i < 1000; i++) cyc(1, i[0], 1000, 0);
      chk("e_count", rec.out_count, 255);
      chk("e_isi", rec.out_isi, 2);

      // ena low for 5 cycles mid-window stretches the window.
      do_reset();
      for (int i = 0; i < 15; i++) begin
         cyc(!(i >= 3 && i < 8), (i >= 3 && i < 8) ? i[0] : 1'b0, 10, 0);
         if (i == 13) chk("f_not_yet", rec.out_valid, 0);
      end
      chk("f_late_valid", rec.out_valid, 1);
      chk("f_count", rec.out_count, 0);
      for (int i = 0; i < 4; i++) cyc(1, i[0], 10, 0);
      do_reset();

      // Randomized traffic with win_len changes and a mid-run reset.
      begin
         int wl_tab[7] = '{0, 1, 2, 3, 5, 7, 13};
         int wl = 5;
         for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 149) == 0) wl = wl_tab[$urandom_range(0, 6)];
            if (i == 1500) do_reset();
            cyc($urandom_range(0, 9) != 0, $urandom_range(0, 2) == 0, wl,
                $urandom_range(0, 3) != 0);
         end
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout: simulation exceeded time bound");
      $fatal(1, "timeout");
   end
endmodule
